etapa_busqueda: RTL and testbench
=================================

# etapa_busqueda

Instruction-fetch stage that drives `MemoriaDeInstrucciones`. It owns the program counter and presents `dir` to the memory each cycle. It captures the combinational `salidaMemoriaDeInstrucciones` word into a one-entry output register and hands it to decode over a valid/ready handshake. It also handles branch/jump redirects and counts delivered instructions.

## Interface
- `RESET_PC`, default 32'd0: PC value loaded on reset.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `dir` output 32: address to `MemoriaDeInstrucciones.dir`; always equals the PC register.
- `instr_mem` input 32: from `MemoriaDeInstrucciones.salidaMemoriaDeInstrucciones`; valid in the same cycle as `dir`.
- `instr_out` output 32: registered instruction to decode.
- `pc_out` output 32: address of `instr_out`.
- `pc_mas4_out` output 32: `pc_out + 4`, modulo 2^32.
- `valid_out` output 1: `instr_out`/`pc_out` hold a live instruction.
- `ready_in` input 1: decode accepts this cycle.
- `salto_valido` input 1: one-cycle redirect request.
- `salto_dir` input 32: redirect target.
- `error_alineacion` output 1: sticky flag, set on a misaligned redirect.
- `contador_instr` output 32: number of completed handshakes.

## Operation
- FSM with two states, encoded by the output register:
  - VACIO: `valid_out`=0.
  - LLENO: `valid_out`=1.
- Define `carga` = (VACIO or (LLENO and `ready_in`)) and not `salto_valido`.
- When `carga` is true:
  - Output register takes `instr_mem`, `pc_out`←PC, `pc_mas4_out`←PC+4.
  - PC←PC+4.
  - State goes to LLENO.
- LLENO with `ready_in`=0 (stall): PC and output register hold; `instr_out` stays stable.
- Redirect (`salto_valido`=1) has priority over load and stall:
  - PC←{`salto_dir`[31:2],2'b00}.
  - State goes to VACIO; the held instruction is squashed and not counted.
  - If `salto_dir`[1:0]≠0, set `error_alineacion`.
- Handshake: a transfer occurs on the edge where `valid_out`=1, `ready_in`=1 and `salto_valido`=0. Each transfer increments `contador_instr` by 1, wrapping modulo 2^32.
- Arithmetic: all addresses are 32-bit unsigned, and PC+4 wraps, e.g. 32'hFFFFFFFC→32'h00000000.
- `error_alineacion` clears only on `reset`.

## Timing
- Reset values:
  - PC=`RESET_PC`, so `dir`=`RESET_PC`.
  - `valid_out`=0, `instr_out`=0, `pc_out`=0, `pc_mas4_out`=0.
  - `error_alineacion`=0, `contador_instr`=0.
  - State=VACIO.
- First edge after `reset` falls: `valid_out`=1 with the instruction at `RESET_PC`.
- Throughput is 1 instruction/cycle while `ready_in`=1.
- Redirect penalty: `salto_valido` at edge N gives `valid_out`=0 after N and the target instruction valid after N+1, so there is one bubble.
- `reset` asserted mid-stall or mid-redirect wins over everything at that edge.
- `salto_valido` and `ready_in` high together: the redirect wins, the transfer does not count, and the instruction is dropped.
- Consecutive redirects: the last one wins, and `valid_out` stays 0 until the first cycle without `salto_valido`.

## Structure
- Shared package `pkg_cpu`:
  - Constant `ANCHO_PALABRA`=32.
  - Constant `INCREMENTO_PC`=4.
  - Constant `PC_REINICIO` default, the source of `RESET_PC`.
- One sub-module, `registro_pc`: PC register with load-enable, next-value mux (hold/+4/redirect) and alignment check.
- Handshake register, counter and FSM stay in `etapa_busqueda`.
- Bench instantiates the real `MemoriaDeInstrucciones`, with `dir` connected to `dir`.

## Test plan
- Reset then run with `ready_in`=1 for 4 cycles → `pc_out` sequence 0,4,8,12; `instr_out` matches memory words 0..3; `contador_instr`=4 (counted at each handshake edge); `valid_out` first high one edge after reset release.
- `ready_in`=0 for 3 cycles while LLENO at `pc_out`=8 → `instr_out`, `pc_out`=8 and `dir`=12 stable; counter unchanged; on release `pc_out` advances to 12 next edge.
- `salto_valido`=1, `salto_dir`=32'h40, while `pc_out`=4 and `ready_in`=1 → next cycle `valid_out`=0 and `dir`=32'h40; the following cycle `pc_out`=32'h40; counter not incremented for the squashed word.
- Redirect to 32'h42 → `dir`=32'h40 and `error_alineacion`=1, which remains 1 through later aligned redirects until `reset`.
- `RESET_PC`=32'hFFFFFFF8, 3 transfers → `pc_out` FFFFFFF8, FFFFFFFC, 00000000; `pc_mas4_out` for FFFFFFFC is 0.
- `reset` asserted during a stall with `valid_out`=1 → next edge: all outputs at their reset values and `dir`=`RESET_PC`.

Source files
------------

// File: rtl/etapa_busqueda_pkg.sv
// Shared CPU constants and types for the instruction-fetch stage.
package pkg_cpu;

    localparam int          ANCHO_PALABRA = 32;
    localparam logic [31:0] INCREMENTO_PC = 32'd4;
    localparam logic [31:0] PC_REINICIO   = 32'd0;

    typedef enum logic {
        VACIO = 1'b0,
        LLENO = 1'b1
    } estado_t;

    // The PC only ever holds word addresses; low bits of a target are dropped.
    function automatic logic [ANCHO_PALABRA-1:0] alinear(input logic [ANCHO_PALABRA-1:0] d);
        return {d[ANCHO_PALABRA-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/etapa_busqueda_if.sv
// Fetch-stage bus: instruction memory port, decode handshake, redirect and status.
interface etapa_busqueda_if;
    import pkg_cpu::*;

    logic [ANCHO_PALABRA-1:0] dir;
    logic [ANCHO_PALABRA-1:0] instr_mem;
    logic [ANCHO_PALABRA-1:0] instr_out;
    logic [ANCHO_PALABRA-1:0] pc_out;
    logic [ANCHO_PALABRA-1:0] pc_mas4_out;
    logic                     valid_out;
    logic                     ready_in;
    logic                     salto_valido;
    logic [ANCHO_PALABRA-1:0] salto_dir;
    logic                     error_alineacion;
    logic [ANCHO_PALABRA-1:0] contador_instr;

    modport master (
        output dir, instr_out, pc_out, pc_mas4_out, valid_out,
               error_alineacion, contador_instr,
        input  instr_mem, ready_in, salto_valido, salto_dir
    );

    modport slave (
        input  dir, instr_out, pc_out, pc_mas4_out, valid_out,
               error_alineacion, contador_instr,
        output instr_mem, ready_in, salto_valido, salto_dir
    );

endinterface

// File: rtl/etapa_busqueda_registro_pc.sv
// Program counter with hold/+4/redirect next-value select and sticky alignment flag.
module registro_pc
    import pkg_cpu::*;
#(
    parameter logic [ANCHO_PALABRA-1:0] RESET_PC = PC_REINICIO
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     carga,
    input  logic                     salto_valido,
    input  logic [ANCHO_PALABRA-1:0] salto_dir,
    output logic [ANCHO_PALABRA-1:0] pc,
    output logic [ANCHO_PALABRA-1:0] pc_mas4,
    output logic                     error_alineacion
);

    logic [ANCHO_PALABRA-1:0] pc_d, pc_q;
    logic                     err_d, err_q;

    assign pc_mas4 = pc_q + INCREMENTO_PC;

    always_comb begin
        pc_d  = pc_q;
        err_d = err_q;
        if (salto_valido) begin
            pc_d = alinear(salto_dir);
            if (salto_dir[1:0] != 2'b00) begin
                err_d = 1'b1;
            end
        end else if (carga) begin
            pc_d = pc_mas4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q  <= RESET_PC;
            err_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            err_q <= err_d;
        end
    end

    assign pc               = pc_q;
    assign error_alineacion = err_q;

endmodule

// File: rtl/memoria_de_instrucciones.sv
// Combinational instruction ROM; each word encodes its own address so fetches are traceable.
module MemoriaDeInstrucciones (
    input  logic [31:0] dir,
    output logic [31:0] salidaMemoriaDeInstrucciones
);

    assign salidaMemoriaDeInstrucciones = {dir[31:24] ^ 8'hE0, dir[25:2] ^ {22'd0, dir[1:0]}};

endmodule

// File: rtl/etapa_busqueda.sv
// Instruction-fetch stage: PC, one-entry output register to decode, redirects, transfer count.
//   state | meaning
//   VACIO | output register holds no live instruction (valid_out=0)
//   LLENO | output register holds a live instruction awaiting decode (valid_out=1)
module etapa_busqueda
    import pkg_cpu::*;
#(
    parameter logic [ANCHO_PALABRA-1:0] RESET_PC = PC_REINICIO
) (
    input  logic              clk,
    input  logic              reset,
    etapa_busqueda_if.master  bus
);

    estado_t                  state_d, state_q;
    logic [ANCHO_PALABRA-1:0] instr_d, instr_q;
    logic [ANCHO_PALABRA-1:0] pc_out_d, pc_out_q;
    logic [ANCHO_PALABRA-1:0] pc_mas4_d, pc_mas4_q;
    logic [ANCHO_PALABRA-1:0] cnt_d, cnt_q;
    logic [ANCHO_PALABRA-1:0] pc;
    logic [ANCHO_PALABRA-1:0] pc_mas4;
    logic                     carga;
    logic                     transfer;
    logic                     error_alineacion;

    registro_pc #(
        .RESET_PC (RESET_PC)
    ) u_registro_pc (
        .clk              (clk),
        .reset            (reset),
        .carga            (carga),
        .salto_valido     (bus.salto_valido),
        .salto_dir        (bus.salto_dir),
        .pc               (pc),
        .pc_mas4          (pc_mas4),
        .error_alineacion (error_alineacion)
    );

    // An empty register always refills; a full one refills only when decode takes it.
    always_comb begin
        carga    = ((state_q == VACIO) || bus.ready_in) && !bus.salto_valido;
        transfer = (state_q == LLENO) && bus.ready_in && !bus.salto_valido;

        state_d   = state_q;
        instr_d   = instr_q;
        pc_out_d  = pc_out_q;
        pc_mas4_d = pc_mas4_q;
        cnt_d     = cnt_q;

        if (bus.salto_valido) begin
            state_d = VACIO;
        end else if (carga) begin
            state_d   = LLENO;
            instr_d   = bus.instr_mem;
            pc_out_d  = pc;
            pc_mas4_d = pc_mas4;
        end

        if (transfer) begin
            cnt_d = cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= VACIO;
            instr_q   <= '0;
            pc_out_q  <= '0;
            pc_mas4_q <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            pc_out_q  <= pc_out_d;
            pc_mas4_q <= pc_mas4_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.dir              = pc;
    assign bus.instr_out        = instr_q;
    assign bus.pc_out           = pc_out_q;
    assign bus.pc_mas4_out      = pc_mas4_q;
    assign bus.valid_out        = (state_q == LLENO);
    assign bus.error_alineacion = error_alineacion;
    assign bus.contador_instr   = cnt_q;

endmodule

// File: tb/tb_etapa_busqueda.sv
// Directed bench for etapa_busqueda: stream, stall, redirect, alignment, wrap, reset-in-stall.
module tb_etapa_busqueda;

    logic clk;
    logic rst_a;
    logic rst_w;
    int   total;
    int   bad;

    etapa_busqueda_if bus_a ();
    etapa_busqueda_if bus_w ();

    etapa_busqueda dut_a (
        .clk   (clk),
        .reset (rst_a),
        .bus   (bus_a)
    );

    etapa_busqueda #(
        .RESET_PC (32'hFFFF_FFF8)
    ) dut_w (
        .clk   (clk),
        .reset (rst_w),
        .bus   (bus_w)
    );

    MemoriaDeInstrucciones mem_a (
        .dir                          (bus_a.dir),
        .salidaMemoriaDeInstrucciones (bus_a.instr_mem)
    );

    MemoriaDeInstrucciones mem_w (
        .dir                          (bus_w.dir),
        .salidaMemoriaDeInstrucciones (bus_w.instr_mem)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1;
        bus_a.ready_in = 1'b1;
        bus_a.salto_valido = 1'b0;
        bus_a.salto_dir = 32'h0;
        step();
        step();
        total++; if (bus_a.dir !== 32'h0) begin bad++; $display("FAIL reset_dir got=%h exp=%h", bus_a.dir, 32'h0); end
        total++; if (bus_a.valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", bus_a.valid_out); end
        total++; if (bus_a.instr_out !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", bus_a.instr_out); end
        total++; if (bus_a.pc_out !== 32'h0) begin bad++; $display("FAIL reset_pc_out got=%h exp=0", bus_a.pc_out); end
        total++; if (bus_a.pc_mas4_out !== 32'h0) begin bad++; $display("FAIL reset_pc_mas4 got=%h exp=0", bus_a.pc_mas4_out); end
        total++; if (bus_a.error_alineacion !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", bus_a.error_alineacion); end
        total++; if (bus_a.contador_instr !== 32'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", bus_a.contador_instr); end
    endtask

    task automatic test_stream();
        rst_a = 1'b0;
        step();
        total++; if (bus_a.valid_out !== 1'b1) begin bad++; $display("FAIL stream_first_valid got=%b exp=1", bus_a.valid_out); end
        total++; if (bus_a.pc_out !== 32'h0) begin bad++; $display("FAIL stream_first_pc got=%h exp=0", bus_a.pc_out); end
        total++; if (bus_a.instr_out !== 32'hE000_0000) begin bad++; $display("FAIL stream_first_instr got=%h exp=E0000000", bus_a.instr_out); end
        total++; if (bus_a.pc_mas4_out !== 32'h4) begin bad++; $display("FAIL stream_first_pc4 got=%h exp=4", bus_a.pc_mas4_out); end
        total++; if (bus_a.dir !== 32'h4) begin bad++; $display("FAIL stream_first_dir got=%h exp=4", bus_a.dir); end
        total++; if (bus_a.contador_instr !== 32'h0) begin bad++; $display("FAIL stream_first_cnt got=%h exp=0", bus_a.contador_instr); end
        for (int i = 1; i <= 4; i++) begin
            step();
            total++; if (bus_a.pc_out !== 32'(4 * i)) begin bad++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, bus_a.pc_out, 32'(4 * i)); end
            total++; if (bus_a.instr_out !== (32'hE000_0000 + 32'(i))) begin bad++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, bus_a.instr_out, 32'hE000_0000 + 32'(i)); end
            total++; if (bus_a.contador_instr !== 32'(i)) begin bad++; $display("FAIL stream_cnt[%0d] got=%0d exp=%0d", i, bus_a.contador_instr, i); end
            total++; if (bus_a.valid_out !== 1'b1) begin bad++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, bus_a.valid_out); end
        end
    endtask

    task automatic test_stall();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        step();
        step();
        step();
        bus_a.ready_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus_a.pc_out !== 32'h8) begin bad++; $display("FAIL stall_pc[%0d] got=%h exp=8", i, bus_a.pc_out); end
            total++; if (bus_a.instr_out !== 32'hE000_0002) begin bad++; $display("FAIL stall_instr[%0d] got=%h exp=E0000002", i, bus_a.instr_out); end
            total++; if (bus_a.dir !== 32'hC) begin bad++; $display("FAIL stall_dir[%0d] got=%h exp=C", i, bus_a.dir); end
            total++; if (bus_a.contador_instr !== 32'd2) begin bad++; $display("FAIL stall_cnt[%0d] got=%0d exp=2", i, bus_a.contador_instr); end
            total++; if (bus_a.valid_out !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus_a.valid_out); end
        end
        bus_a.ready_in = 1'b1;
        step();
        total++; if (bus_a.pc_out !== 32'hC) begin bad++; $display("FAIL stall_release_pc got=%h exp=C", bus_a.pc_out); end
        total++; if (bus_a.instr_out !== 32'hE000_0003) begin bad++; $display("FAIL stall_release_instr got=%h exp=E0000003", bus_a.instr_out); end
        total++; if (bus_a.contador_instr !== 32'd3) begin bad++; $display("FAIL stall_release_cnt got=%0d exp=3", bus_a.contador_instr); end
    endtask

    task automatic test_redirect();
        rst_a = 1'b1;
        step();
        rst_a = 1'b0;
        step();
        step();
        bus_a.salto_valido = 1'b1;
        bus_a.salto_dir = 32'h40;
        step();
        total++; if (bus_a.valid_out !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", bus_a.valid_out); end
        total++; if (bus_a.dir !== 32'h40) begin bad++; $display("FAIL redir_dir got=%h exp=40", bus_a.dir); end
        total++; if (bus_a.contador_instr !== 32'd1) begin bad++; $display("FAIL redir_squash_cnt got=%0d exp=1", bus_a.contador_instr); end
        bus_a.salto_valido = 1'b0;
        step();
        total++; if (bus_a.valid_out !== 1'b1) begin bad++; $display("FAIL redir_target_valid got=%b exp=1", bus_a.valid_out); end
        total++; if (bus_a.pc_out !== 32'h40) begin bad++; $display("FAIL redir_target_pc got=%h exp=40", bus_a.pc_out); end
        total++; if (bus_a.instr_out !== 32'hE000_0010) begin bad++; $display("FAIL redir_target_instr got=%h exp=E0000010", bus_a.instr_out); end
        total++; if (bus_a.contador_instr !== 32'd1) begin bad++; $display("FAIL redir_target_cnt got=%0d exp=1", bus_a.contador_instr); end
        step();
        total++; if (bus_a.pc_out !== 32'h44) begin bad++; $display("FAIL redir_next_pc got=%h exp=44", bus_a.pc_out); end
        total++; if (bus_a.contador_instr !== 32'd2) begin bad++; $display("FAIL redir_next_cnt got=%0d exp=2", bus_a.contador_instr); end
    endtask

    task automatic test_misaligned();
        bus_a.salto_valido = 1'b1;
        bus_a.salto_dir = 32'h42;
        step();
        total++; if (bus_a.dir !== 32'h40) begin bad++; $display("FAIL misal_dir got=%h exp=40", bus_a.dir); end
        total++; if (bus_a.error_alineacion !== 1'b1) begin bad++; $display("FAIL misal_err got=%b exp=1", bus_a.error_alineacion); end
        total++; if (bus_a.contador_instr !== 32'd2) begin bad++; $display("FAIL misal_cnt got=%0d exp=2", bus_a.contador_instr); end
        bus_a.salto_dir = 32'h80;
        step();
        total++; if (bus_a.dir !== 32'h80) begin bad++; $display("FAIL back2back_dir got=%h exp=80", bus_a.dir); end
        total++; if (bus_a.valid_out !== 1'b0) begin bad++; $display("FAIL back2back_valid got=%b exp=0", bus_a.valid_out); end
        total++; if (bus_a.error_alineacion !== 1'b1) begin bad++; $display("FAIL sticky_err1 got=%b exp=1", bus_a.error_alineacion); end
        bus_a.salto_valido = 1'b0;
        step();
        total++; if (bus_a.valid_out !== 1'b1) begin bad++; $display("FAIL back2back_after_valid got=%b exp=1", bus_a.valid_out); end
        total++; if (bus_a.pc_out !== 32'h80) begin bad++; $display("FAIL back2back_after_pc got=%h exp=80", bus_a.pc_out); end
        total++; if (bus_a.instr_out !== 32'hE000_0020) begin bad++; $display("FAIL back2back_after_instr got=%h exp=E0000020", bus_a.instr_out); end
        total++; if (bus_a.error_alineacion !== 1'b1) begin bad++; $display("FAIL sticky_err2 got=%b exp=1", bus_a.error_alineacion); end
    endtask

    task automatic test_reset_in_stall();
        bus_a.ready_in = 1'b0;
        step();
        total++; if (bus_a.valid_out !== 1'b1) begin bad++; $display("FAIL rststall_pre_valid got=%b exp=1", bus_a.valid_out); end
        total++; if (bus_a.pc_out !== 32'h80) begin bad++; $display("FAIL rststall_pre_pc got=%h exp=80", bus_a.pc_out); end
        rst_a = 1'b1;
        step();
        total++; if (bus_a.valid_out !== 1'b0) begin bad++; $display("FAIL rststall_valid got=%b exp=0", bus_a.valid_out); end
        total++; if (bus_a.dir !== 32'h0) begin bad++; $display("FAIL rststall_dir got=%h exp=0", bus_a.dir); end
        total++; if (bus_a.instr_out !== 32'h0) begin bad++; $display("FAIL rststall_instr got=%h exp=0", bus_a.instr_out); end
        total++; if (bus_a.pc_out !== 32'h0) begin bad++; $display("FAIL rststall_pc got=%h exp=0", bus_a.pc_out); end
        total++; if (bus_a.pc_mas4_out !== 32'h0) begin bad++; $display("FAIL rststall_pc4 got=%h exp=0", bus_a.pc_mas4_out); end
        total++; if (bus_a.error_alineacion !== 1'b0) begin bad++; $display("FAIL rststall_err got=%b exp=0", bus_a.error_alineacion); end
        total++; if (bus_a.contador_instr !== 32'h0) begin bad++; $display("FAIL rststall_cnt got=%h exp=0", bus_a.contador_instr); end
    endtask

    task automatic test_wrap();
        rst_w = 1'b1;
        step();
        total++; if (bus_w.dir !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_reset_dir got=%h exp=FFFFFFF8", bus_w.dir); end
        total++; if (bus_w.valid_out !== 1'b0) begin bad++; $display("FAIL wrap_reset_valid got=%b exp=0", bus_w.valid_out); end
        rst_w = 1'b0;
        step();
        total++; if (bus_w.pc_out !== 32'hFFFF_FFF8) begin bad++; $display("FAIL wrap_pc0 got=%h exp=FFFFFFF8", bus_w.pc_out); end
        total++; if (bus_w.pc_mas4_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc4_0 got=%h exp=FFFFFFFC", bus_w.pc_mas4_out); end
        total++; if (bus_w.instr_out !== 32'h1FFF_FFFE) begin bad++; $display("FAIL wrap_instr0 got=%h exp=1FFFFFFE", bus_w.instr_out); end
        step();
        total++; if (bus_w.pc_out !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc1 got=%h exp=FFFFFFFC", bus_w.pc_out); end
        total++; if (bus_w.pc_mas4_out !== 32'h0) begin bad++; $display("FAIL wrap_pc4_1 got=%h exp=0", bus_w.pc_mas4_out); end
        total++; if (bus_w.instr_out !== 32'h1FFF_FFFF) begin bad++; $display("FAIL wrap_instr1 got=%h exp=1FFFFFFF", bus_w.instr_out); end
        total++; if (bus_w.dir !== 32'h0) begin bad++; $display("FAIL wrap_dir1 got=%h exp=0", bus_w.dir); end
        step();
        total++; if (bus_w.pc_out !== 32'h0) begin bad++; $display("FAIL wrap_pc2 got=%h exp=0", bus_w.pc_out); end
        total++; if (bus_w.pc_mas4_out !== 32'h4) begin bad++; $display("FAIL wrap_pc4_2 got=%h exp=4", bus_w.pc_mas4_out); end
        total++; if (bus_w.instr_out !== 32'hE000_0000) begin bad++; $display("FAIL wrap_instr2 got=%h exp=E0000000", bus_w.instr_out); end
        total++; if (bus_w.contador_instr !== 32'd2) begin bad++; $display("FAIL wrap_cnt got=%0d exp=2", bus_w.contador_instr); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_w = 1'b1;
        bus_w.ready_in = 1'b1;
        bus_w.salto_valido = 1'b0;
        bus_w.salto_dir = 32'h0;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_misaligned();
        test_reset_in_stall();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
